// File: rtl/sw_line_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_line_unpacker_if
// Description : Job control, DMA read-line and base-stream signals of the
//               Smith-Waterman line unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_line_unpacker_if #(
    parameter int LINE_W = 512,
    parameter int SYM_W  = 2,
    parameter int LEN_W  = 32
);
    logic              start;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    logic              read_data_ready;
    logic [0:LINE_W-1] read_data;
    logic              read_data_ack;

    logic              out_valid;
    logic              out_ready;
    logic [0:SYM_W-1]  out_base;
    logic [LEN_W-1:0]  out_pos;
    logic              out_last;

    // master = job logic / DMA / systolic array side, slave = the unpacker
    modport master (
        output start, length, read_data_ready, read_data, out_ready,
        input  busy, done, read_data_ack, out_valid, out_base, out_pos, out_last
    );

    modport slave (
        input  start, length, read_data_ready, read_data, out_ready,
        output busy, done, read_data_ack, out_valid, out_base, out_pos, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sw_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : sw_line_unpacker
// Description : Unpacks 512-bit DMA read lines into a one-per-cycle stream of
//               2-bit nucleotide codes using two ping-pong line slots.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_line_unpacker #(
    parameter int LINE_W = 512,
    parameter int SYM_W  = 2,
    parameter int LEN_W  = 32
) (
    input  wire logic          ha_pclock,
    input  wire logic          reset_n,
    sw_line_unpacker_if.slave  bus
);
    localparam int SYMS  = LINE_W / SYM_W;
    localparam int PTR_W = $clog2(SYMS);
    localparam int BIT_W = $clog2(LINE_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  pos;
    logic [LEN_W:0]    lines_needed;
    logic [LEN_W:0]    lines_acked;
    logic [1:0]        fill_cnt;
    logic              head;
    logic              tail;
    logic [PTR_W-1:0]  sym_ptr;
    logic [0:LINE_W-1] slot0;
    logic [0:LINE_W-1] slot1;

    logic [0:LINE_W-1] head_slot;
    logic [BIT_W-1:0]  bit_idx;
    logic              ack;
    logic              valid;
    logic              last;
    logic              hs;
    logic              line_end;

    always_comb begin
        ack       = (state == S_RUN) && bus.read_data_ready &&
                    (fill_cnt < 2'd2) && (lines_acked < lines_needed);
        valid     = (state == S_RUN) && (fill_cnt != 2'd0);
        last      = valid && (pos == len_q - LEN_W'(1));
        hs        = valid && bus.out_ready;
        line_end  = (sym_ptr == PTR_W'(SYMS - 1)) || last;
        head_slot = head ? slot1 : slot0;
        bit_idx   = BIT_W'(sym_ptr) * BIT_W'(SYM_W);
    end

    // State register
    always_ff @(posedge ha_pclock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (hs && last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy          = (state == S_RUN);
        bus.done          = (state == S_DONE);
        bus.read_data_ack = ack;
        bus.out_valid     = valid;
        bus.out_base      = head_slot[bit_idx +: SYM_W];
        bus.out_pos       = pos;
        bus.out_last      = last;
    end

    always_ff @(posedge ha_pclock) begin
        if (!reset_n) begin
            len_q        <= '0;
            pos          <= '0;
            lines_needed <= '0;
            lines_acked  <= '0;
            fill_cnt     <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            sym_ptr      <= '0;
            slot0        <= '0;
            slot1        <= '0;
        end else begin
            if ((state == S_IDLE) && bus.start) begin
                len_q        <= bus.length;
                pos          <= '0;
                lines_acked  <= '0;
                lines_needed <= ({1'b0, bus.length} + (LEN_W+1)'(SYMS - 1)) >> PTR_W;
            end

            if (ack) begin
                if (tail) begin
                    slot1 <= bus.read_data;
                end else begin
                    slot0 <= bus.read_data;
                end
                tail        <= ~tail;
                lines_acked <= lines_acked + (LEN_W+1)'(1);
            end

            if (hs) begin
                pos <= pos + LEN_W'(1);
                if (line_end) begin
                    sym_ptr <= '0;
                    head    <= ~head;
                end else begin
                    sym_ptr <= sym_ptr + PTR_W'(1);
                end
            end

            fill_cnt <= fill_cnt + {1'b0, ack} - {1'b0, hs && line_end};

            // Final line: drop the unused tail symbols so the next job starts clean
            if (hs && last) begin
                slot0    <= '0;
                slot1    <= '0;
                fill_cnt <= 2'd0;
                head     <= 1'b0;
                tail     <= 1'b0;
                sym_ptr  <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sw_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_line_unpacker
// Description : Randomised self-checking bench for sw_line_unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_line_unpacker;
    localparam int LINE_W = 512;
    localparam int SYM_W  = 2;
    localparam int LEN_W  = 32;
    localparam int SYMS   = LINE_W / SYM_W;

    logic ha_pclock;
    logic reset_n;
    int   compared;
    int   mismatched;

    logic [LINE_W-1:0] lines [0:15];

    sw_line_unpacker_if #(.LINE_W(LINE_W), .SYM_W(SYM_W), .LEN_W(LEN_W)) bus ();

    sw_line_unpacker #(.LINE_W(LINE_W), .SYM_W(SYM_W), .LEN_W(LEN_W)) dut (
        .ha_pclock (ha_pclock),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    initial ha_pclock = 1'b0;
    always #5 ha_pclock = ~ha_pclock;

    task automatic fill_lines(input bit fixed_pat);
        for (int l = 0; l < 16; l++) begin
            for (int w = 0; w < LINE_W / 32; w++) begin
                lines[l][w*32 +: 32] = fixed_pat ? 32'h1B1B_1B1B : $urandom;
            end
        end
    endtask

    // Base k of the job: lines are big-endian, base 0 in the two MSBs of line 0
    function automatic int model_base(input int k);
        logic [LINE_W-1:0] ln;
        ln = lines[k / SYMS];
        return int'((ln >> (LINE_W - SYM_W - SYM_W * (k % SYMS))) & 3);
    endfunction

    task automatic idle_inputs();
        bus.start           = 1'b0;
        bus.length          = '0;
        bus.read_data_ready = 1'b0;
        bus.read_data       = '0;
        bus.out_ready       = 1'b0;
    endtask

    // bp_mode: 0 always ready, 1 stalled cycles 5..24, 2 random
    task automatic run_job(input int len, input int bp_mode, input bit dma_rand,
                           input int inject_at, input bit check_nobubble);
        int  needed, acks, freed, emitted, done_cnt, valid_cnt, busy_cnt;
        int  last_hs_cyc, first_ack_cyc, post, exp_b;
        bit  finished, prev_stall;
        logic [SYM_W-1:0] prev_base;
        logic [LEN_W-1:0] prev_pos;
        int  budget;
        needed = (len + SYMS - 1) / SYMS;
        acks = 0; freed = 0; emitted = 0; done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        last_hs_cyc = 0; first_ack_cyc = -1; post = 0;
        finished = 0; prev_stall = 0; prev_base = '0; prev_pos = '0;
        budget = len * 4 + 200;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(posedge ha_pclock); #1;
            bus.start  = (cyc == 0) || (cyc == inject_at);
            bus.length = (cyc == 0) ? LEN_W'(len) : LEN_W'(8);
            case (bp_mode)
                1:       bus.out_ready = !(cyc >= 5 && cyc <= 24);
                2:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b1;
            endcase
            bus.read_data_ready = dma_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.read_data       = lines[acks < 16 ? acks : 15];
            #2;
            if (bus.busy) busy_cnt++;
            if (cyc == 1) begin
                compared++;
                if (bus.busy !== (len != 0)) begin
                    mismatched++;
                    $display("FAIL busy_after_start: got %b required %b", bus.busy, len != 0);
                end
            end
            if (prev_stall) begin
                compared++;
                if (bus.out_valid !== 1'b1 || bus.out_base !== prev_base || bus.out_pos !== prev_pos) begin
                    mismatched++;
                    $display("FAIL hold: valid=%b base=%0d pos=%0d required base=%0d pos=%0d",
                             bus.out_valid, bus.out_base, bus.out_pos, prev_base, prev_pos);
                end
            end
            if (bus.read_data_ack === 1'b1) begin
                acks++;
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
                compared++;
                if (acks > needed || acks - freed > 2) begin
                    mismatched++;
                    $display("FAIL ack_limit: acks=%0d outstanding=%0d required acks<=%0d outstanding<=2",
                             acks, acks - freed, needed);
                end
            end
            if (check_nobubble && first_ack_cyc >= 0 && cyc > first_ack_cyc && cyc <= first_ack_cyc + len) begin
                compared++;
                if (bus.out_valid !== 1'b1 || bus.out_ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL no_bubble: cyc=%0d valid=%b required 1", cyc, bus.out_valid);
                end
            end
            if (bus.out_valid === 1'b1) begin
                valid_cnt++;
                exp_b = model_base(emitted);
                compared++;
                if (int'(bus.out_base) != exp_b || bus.out_pos !== LEN_W'(emitted) ||
                    bus.out_last !== (emitted == len - 1)) begin
                    mismatched++;
                    $display("FAIL stream: idx=%0d base=%0d pos=%0d last=%b required base=%0d pos=%0d last=%b",
                             emitted, bus.out_base, bus.out_pos, bus.out_last, exp_b, emitted, emitted == len - 1);
                end
                prev_stall = !bus.out_ready;
                prev_base  = bus.out_base;
                prev_pos   = bus.out_pos;
                if (bus.out_ready) begin
                    if ((emitted % SYMS) == SYMS - 1 || emitted == len - 1) freed++;
                    if (emitted == len - 1) last_hs_cyc = cyc;
                    emitted++;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                compared++;
                if (cyc != last_hs_cyc + 1 || bus.busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL done_timing: cyc=%0d busy=%b required cyc=%0d busy=0",
                             cyc, bus.busy, last_hs_cyc + 1);
                end
            end
            if (done_cnt > 0) begin
                post++;
                if (post > 3) finished = 1;
            end
        end
        idle_inputs();
        compared++;
        if (!finished) begin
            mismatched++;
            $display("FAIL timeout: len=%0d emitted=%0d required done within %0d cycles", len, emitted, budget);
        end
        compared++;
        if (emitted != len || acks != needed || done_cnt != 1) begin
            mismatched++;
            $display("FAIL job_totals len=%0d: bases=%0d acks=%0d dones=%0d required %0d/%0d/1",
                     len, emitted, acks, done_cnt, len, needed);
        end
        if (len == 0) begin
            compared++;
            if (valid_cnt != 0 || busy_cnt != 0) begin
                mismatched++;
                $display("FAIL zero_len: valid cycles=%0d busy cycles=%0d required 0/0", valid_cnt, busy_cnt);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge ha_pclock);
        #3;
        compared++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.read_data_ack !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_base !== 2'b00 || bus.out_pos !== '0 || bus.out_last !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: busy=%b done=%b ack=%b valid=%b base=%0d pos=%0d last=%b required all 0",
                     bus.busy, bus.done, bus.read_data_ack, bus.out_valid, bus.out_base, bus.out_pos, bus.out_last);
        end
        @(posedge ha_pclock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_zero_length();
        fill_lines(1'b0);
        run_job(0, 0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_single_line();
        fill_lines(1'b1);
        run_job(256, 0, 1'b0, -1, 1'b1);
    endtask

    task automatic test_partial_line();
        fill_lines(1'b0);
        run_job(300, 0, 1'b0, -1, 1'b1);
    endtask

    task automatic test_backpressure();
        fill_lines(1'b0);
        run_job(600, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_lines(1'b0);
        run_job(1024, 0, 1'b0, -1, 1'b1);
    endtask

    task automatic test_ignored_start();
        fill_lines(1'b0);
        run_job(300, 0, 1'b0, 40, 1'b0);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 4; j++) begin
            fill_lines(1'b0);
            run_job(int'($urandom_range(1, 900)), 2, 1'b1, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_job();
        int bad;
        fill_lines(1'b0);
        @(posedge ha_pclock); #1;
        bus.start = 1'b1; bus.length = LEN_W'(600);
        bus.read_data_ready = 1'b1; bus.out_ready = 1'b1; bus.read_data = lines[0];
        @(posedge ha_pclock); #1;
        bus.start = 1'b0;
        repeat (40) @(posedge ha_pclock);
        #1;
        reset_n = 1'b0;
        @(posedge ha_pclock); #1;
        reset_n = 1'b1;
        #2;
        compared++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: busy=%b valid=%b done=%b required 0/0/0", bus.busy, bus.out_valid, bus.done);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge ha_pclock); #3;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL reset_no_done: %0d cycles with done/busy, required 0", bad);
        end
        idle_inputs();
        run_job(4, 0, 1'b0, -1, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_zero_length();
        test_single_line();
        test_partial_line();
        test_backpressure();
        test_back_to_back();
        test_ignored_start();
        test_random_jobs();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
